// File: rtl/mm_job_sequencer.sv
// Sequences one 3x3 matrix-multiply job: operand stream in, core load/compute, result stream out.
// Optional result-read watchdog is compiled in with MM_JOB_SEQ_TIMEOUT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for the first operand; core held out of reset
// S_CLEAR     | one-cycle core reset before loading
// S_LOAD      | accepting operand nibbles, one enable pulse per nibble
// S_COMPUTE   | free-running enables while the core finishes the products
// S_READ_SEL  | result address driven, waiting for mm_done to capture
// S_READ_WAIT | result presented downstream, waiting for res_ready
module mm_job_sequencer #(
    parameter int N_OPERANDS     = 18,
    parameter int COMPUTE_CYCLES = 9,
    parameter int N_RESULTS      = 9
`ifdef MM_JOB_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_data,
    output logic       res_last,
    output logic       busy,
    output logic       err,
    output logic       mm_reset,
    output logic       mm_enable,
    output logic [3:0] mm_data_in,
    output logic [3:0] mm_out_sel,
    input  logic [9:0] mm_data_out,
    input  logic       mm_done
);

    localparam int OP_W  = $clog2(N_OPERANDS);
    localparam int CMP_W = $clog2(COMPUTE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_READ_SEL,
        S_READ_WAIT
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op_cnt;
    logic [CMP_W-1:0]  cmp_cnt;
    logic [3:0]        idx;

    assign mm_out_sel = idx;

`ifdef MM_JOB_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= S_IDLE;
            op_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_last   <= 1'b0;
            res_data   <= '0;
            busy       <= 1'b0;
            mm_reset   <= 1'b1;
            mm_enable  <= 1'b0;
            mm_data_in <= '0;
            idx        <= '0;
            op_cnt     <= '0;
            cmp_cnt    <= '0;
`ifdef MM_JOB_SEQ_TIMEOUT_EN
            err        <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
`ifdef MM_JOB_SEQ_TIMEOUT_EN
            if (state != S_READ_SEL)
                wd_cnt <= '0;
`endif
            case (state)
                S_IDLE: begin
                    mm_reset  <= 1'b0;
                    mm_enable <= 1'b0;
                    // The nibble that woke us is not consumed; op_ready rises only in LOAD.
                    if (op_valid) begin
                        mm_reset <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    mm_reset <= 1'b0;
                    op_cnt   <= '0;
                    op_ready <= 1'b1;
                    state    <= S_LOAD;
                end

                S_LOAD: begin
                    if (op_valid) begin
                        mm_data_in <= op_data;
                        mm_enable  <= 1'b1;
                        op_cnt     <= op_cnt + 1'b1;
                        if (op_cnt == OP_W'(N_OPERANDS - 1)) begin
                            op_ready <= 1'b0;
                            cmp_cnt  <= '0;
                            state    <= S_COMPUTE;
                        end
                    end else begin
                        mm_enable <= 1'b0;
                    end
                end

                S_COMPUTE: begin
                    mm_enable <= 1'b1;
                    if (cmp_cnt == CMP_W'(COMPUTE_CYCLES - 1)) begin
                        idx   <= '0;
                        state <= S_READ_SEL;
                    end else begin
                        cmp_cnt <= cmp_cnt + 1'b1;
                    end
                end

                S_READ_SEL: begin
                    mm_enable <= 1'b1;
                    if (mm_done) begin
                        res_data  <= mm_data_out;
                        res_valid <= 1'b1;
                        res_last  <= (idx == 4'(N_RESULTS - 1));
                        state     <= S_READ_WAIT;
                    end
`ifdef MM_JOB_SEQ_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Core never answered: abandon the job and kick the core once.
                        err       <= 1'b1;
                        mm_reset  <= 1'b1;
                        mm_enable <= 1'b0;
                        busy      <= 1'b0;
                        idx       <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                S_READ_WAIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (res_last) begin
                            mm_enable <= 1'b0;
                            busy      <= 1'b0;
                            idx       <= '0;
                            state     <= S_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_READ_SEL;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Self-checking bench for mm_job_sequencer: table-driven jobs, hand-written corner sequences
// and randomized jobs checked against a matrix-product reference model.
module tb_mm_job_sequencer;

    logic       clk_i = 1'b0;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_data;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_data;
    logic       res_last;
    logic       busy;
    logic       err;
    logic       mm_reset;
    logic       mm_enable;
    logic [3:0] mm_data_in;
    logic [3:0] mm_out_sel;
    logic [9:0] mm_data_out;
    logic       mm_done;

    always #5 clk_i = ~clk_i;

    mm_job_sequencer dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_data     (op_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .busy        (busy),
        .err         (err),
        .mm_reset    (mm_reset),
        .mm_enable   (mm_enable),
        .mm_data_in  (mm_data_in),
        .mm_out_sel  (mm_out_sel),
        .mm_data_out (mm_data_out),
        .mm_done     (mm_done)
    );

    // Behavioural stand-in for the multiplier core: 18 enabled loads, 9 more enabled clocks, then done.
    logic [3:0] core_ops [18];
    int         core_cnt    = 0;
    logic       hold_nodone = 1'b0;

    always @(posedge clk_i) begin
        if (mm_reset) begin
            core_cnt <= 0;
        end else if (mm_enable) begin
            if (core_cnt < 18) core_ops[core_cnt] <= mm_data_in;
            if (core_cnt < 27) core_cnt <= core_cnt + 1;
        end
    end

    assign mm_done = (core_cnt == 27) && !hold_nodone;

    always_comb begin
        int r, c, s;
        s = 0;
        r = int'(mm_out_sel) / 3;
        c = int'(mm_out_sel) % 3;
        if (mm_out_sel < 4'd9)
            for (int k = 0; k < 3; k++)
                s += int'(core_ops[r*3+k]) * int'(core_ops[9+k*3+c]);
        mm_data_out = 10'(s);
    end

    typedef struct packed {
        logic [17:0][3:0] ops;
        logic [1:0]       gap;
        logic [1:0]       bp;
        logic [8:0][9:0]  exp;
    } vec_t;

    vec_t       vecs [5];
    logic [10:0] exp_q [$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         load_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0][9:0] ref_matmul(input logic [17:0][3:0] ops);
        logic [8:0][9:0] r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(ops[i*3+k]) * int'(ops[9+k*3+j]);
                r[i*3+j] = 10'(s);
            end
        return r;
    endfunction

    // One clock: score a result handshake, cross the edge, then check what the edge produced.
    task automatic tick();
        logic       reset_prev, hs_prev, rdy_prev, rv_prev, rr_prev, rl_prev;
        logic [3:0] d_prev;
        logic [9:0] rd_prev;
        logic [10:0] e;
        reset_prev = reset;
        hs_prev    = op_valid && op_ready;
        rdy_prev   = op_ready;
        d_prev     = op_data;
        rv_prev    = res_valid;
        rr_prev    = res_ready;
        rd_prev    = res_data;
        rl_prev    = res_last;
        if (!reset && res_valid && res_ready) begin
            check("res_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("res_data", res_data, 32'(e[9:0]));
                check("res_last", res_last, 32'(e[10]));
            end
        end
        @(negedge clk_i);
        if (!reset_prev) begin
            if (hs_prev) begin
                check("load_en", mm_enable, 1);
                check("load_data", mm_data_in, d_prev);
                load_pulses++;
            end else if (rdy_prev) begin
                check("load_gap_en", mm_enable, 0);
            end
            if (rv_prev && !rr_prev) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, rd_prev);
                check("hold_last", res_last, rl_prev);
            end
            check("out_sel_range", mm_out_sel < 4'd9, 1);
        end
    endtask

    task automatic feed_ops(input vec_t v);
        int n, cyc;
        logic vld;
        n = 0;
        cyc = 0;
        while (n < 18 && cyc < 500) begin
            case (v.gap)
                2'd0:    vld = 1'b1;
                2'd1:    vld = (cyc % 2 == 0);
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            op_valid  = vld;
            op_data   = vld ? v.ops[n] : 4'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            if (op_valid && op_ready) n++;
            tick();
            cyc++;
        end
        op_valid = 1'b0;
        check("load_bound", n, 18);
    endtask

    task automatic collect(input logic [1:0] bp);
        int stall [9];
        int rcnt, wait_cnt, cyc;
        logic rv, rhs;
        for (int k = 0; k < 9; k++)
            case (bp)
                2'd0:    stall[k] = 0;
                2'd1:    stall[k] = (k == 0 || k == 4) ? 5 : 0;
                default: stall[k] = $urandom_range(0, 3);
            endcase
        rcnt = 0;
        wait_cnt = 0;
        cyc = 0;
        while (rcnt < 9 && cyc < 400) begin
            op_valid  = 1'($urandom_range(0, 1));
            op_data   = 4'($urandom);
            check("op_ready_low", op_ready, 0);
            res_ready = (wait_cnt >= stall[rcnt]);
            rv  = res_valid;
            rhs = res_valid && res_ready;
            tick();
            cyc++;
            if (rhs) begin
                rcnt++;
                wait_cnt = 0;
            end else if (rv) begin
                wait_cnt++;
            end
        end
        op_valid = 1'b0;
        check("result_bound", rcnt, 9);
    endtask

    task automatic run_job(input vec_t v, input int stall_done);
        for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), v.exp[i]});
        load_pulses = 0;
        feed_ops(v);
        for (int t = 0; t < stall_done; t++) begin
            res_ready = 1'b1;
            tick();
            check("stall_no_valid", res_valid, 0);
            check("stall_busy", busy, 1);
        end
        hold_nodone = 1'b0;
        collect(v.bp);
        check("load_pulses", load_pulses, 18);
        check("busy_after_last", busy, 0);
        check("op_ready_idle", op_ready, 0);
        check("err_low", err, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_op_ready", op_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mm_reset", mm_reset, 1);
        check("rst_mm_enable", mm_enable, 0);
        check("rst_mm_data_in", mm_data_in, 0);
        check("rst_mm_out_sel", mm_out_sel, 0);
    endtask

    initial begin
        int n, cyc;
        int rs [3];
        vec_t rv;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_data   = '0;
        res_ready = 1'b0;

        rs = '{6, 15, 24};
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        for (int i = 0; i < 9; i++) begin
            vecs[0].ops[i]   = (i % 4 == 0) ? 4'd1 : 4'd0;
            vecs[0].ops[9+i] = 4'(i + 1);
            vecs[0].exp[i]   = 10'(i + 1);
            vecs[1].ops[i]   = 4'd15;
            vecs[1].ops[9+i] = 4'd15;
            vecs[1].exp[i]   = 10'd675;
            vecs[4].ops[i]   = 4'(i + 1);
            vecs[4].ops[9+i] = 4'd1;
            vecs[4].exp[i]   = 10'(rs[i/3]);
        end
        vecs[2]     = vecs[0];
        vecs[2].gap = 2'd1;
        vecs[3]     = vecs[0];
        vecs[3].bp  = 2'd1;

        repeat (3) tick();
        check_reset_values();
        reset = 1'b0;
        tick();
        check("idle_mm_reset", mm_reset, 0);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_job(vecs[i], 0);

        // Reset lands after the tenth operand of an all-15 job.
        load_pulses = 0;
        op_valid = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 100) begin
            op_data = vecs[1].ops[n];
            if (op_ready) n++;
            tick();
            cyc++;
        end
        check("partial_load", n, 10);
        reset    = 1'b1;
        op_valid = 1'b0;
        tick();
        check_reset_values();
        reset = 1'b0;
        run_job(vecs[0], 0);

`ifdef MM_JOB_SEQ_TIMEOUT_EN
        begin
            int first_err, rst_pulses, saw_valid;
            hold_nodone = 1'b1;
            load_pulses = 0;
            feed_ops(vecs[0]);
            first_err  = 0;
            rst_pulses = 0;
            saw_valid  = 0;
            for (int t = 1; t <= 40; t++) begin
                res_ready = 1'b1;
                tick();
                if (res_valid) saw_valid++;
                if (mm_reset) rst_pulses++;
                if (err && first_err == 0) first_err = t;
            end
            check("timeout_cycle", first_err, 25);
            check("timeout_rst_pulses", rst_pulses, 1);
            check("timeout_no_valid", saw_valid, 0);
            check("timeout_err_sticky", err, 1);
            check("timeout_busy", busy, 0);
            check("timeout_enable", mm_enable, 0);
            hold_nodone = 1'b0;
            reset = 1'b1;
            tick();
            check("timeout_err_cleared", err, 0);
            reset = 1'b0;
            tick();
        end
`else
        hold_nodone = 1'b1;
        run_job(vecs[3], 40);
`endif

        for (int j = 0; j < 6; j++) begin
            rv = '0;
            for (int i = 0; i < 18; i++) rv.ops[i] = 4'($urandom_range(0, 15));
            rv.gap = 2'd2;
            rv.bp  = 2'd2;
            rv.exp = ref_matmul(rv.ops);
            run_job(rv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_job_sequencer.md
Name: mm_job_sequencer

Overview:
- Controller that runs one complete 3x3 matrix-multiply job on the 4-bit-in / 10-bit-out matrix multiplier core.
- Accepts 18 operand nibbles on a valid/ready stream, clears the core, and issues the load and compute enable pulses.
- Reads the 9 products back by address and returns them on a valid/ready result stream.
- Sits between the host-side operand FIFO and the multiplier core. The core is used only through this block.

Parameters:
- N_OPERANDS, 18, operand nibbles per job: 9 for A then 9 for B, row-major.
- COMPUTE_CYCLES, 9, extra enabled clocks after the last operand, before results are valid.
- N_RESULTS, 9, products read back per job; out_sel runs 0..N_RESULTS-1.
- TIMEOUT_CYCLES, 16, watchdog limit per result read (used only with the optional feature).

Ports:
- clk_i  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; sampled on rising clk_i.
- op_valid  in  1  operand nibble available.
- op_ready  out  1  operand accepted this cycle when op_valid && op_ready.
- op_data  in  4  operand nibble.
- res_valid  out  1  result word available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  10  product element.
- res_last  out  1  high with the 9th result (index 8).
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error (optional feature only; tied 0 otherwise).
- mm_reset  out  1  reset to the core.
- mm_enable  out  1  enable to the core.
- mm_data_in  out  4  operand to the core.
- mm_out_sel  out  4  result address to the core.
- mm_data_out  in  10  core result bus, valid combinationally while mm_out_sel is driven.
- mm_done  in  1  core result-valid flag.

Behaviour:
- **Reset** (reset=1 at an edge, from any state):
  - state=IDLE; op_ready=0, res_valid=0, res_last=0, busy=0, err=0, res_data=0.
  - mm_reset=1, mm_enable=0, mm_data_in=0, mm_out_sel=0.
  - All counters cleared. A job in progress is abandoned; no partial results are emitted.
- **Core interface:** mm_data_in, mm_enable, mm_out_sel and mm_reset are registered outputs.
- **IDLE:**
  - mm_reset=0, op_ready=0.
  - op_valid=1 -> CLEAR. The nibble is not consumed.
- **CLEAR** (1 cycle):
  - mm_reset=1, mm_enable=0.
  - Next state: LOAD, with op_cnt=0.
- **LOAD:**
  - op_ready=1.
  - On each handshake: mm_data_in<=op_data, mm_enable<=1 for exactly the following cycle, op_cnt++.
  - No handshake: mm_enable<=0.
  - Handshake with op_cnt=N_OPERANDS-1 -> COMPUTE, op_ready drops the next cycle.
  - Gaps in op_valid are allowed and stall the job.
- **COMPUTE:**
  - op_ready=0, mm_enable=1 for exactly COMPUTE_CYCLES consecutive cycles, counted by cmp_cnt.
  - Then -> READ_SEL with idx=0.
- **READ_SEL:**
  - Drive mm_enable=1 and mm_out_sel=idx.
  - On the next edge, if mm_done=1: res_data<=mm_data_out, res_valid<=1, res_last<=(idx==N_RESULTS-1) -> READ_WAIT.
  - If mm_done=0: stay in READ_SEL (watchdog counting if enabled).
- **READ_WAIT:**
  - Hold res_data, res_valid and res_last stable until res_ready.
  - On res_valid && res_ready: res_valid<=0.
    - If res_last: -> IDLE, mm_enable<=0.
    - Else: idx++ -> READ_SEL.
- **Throughput and latency:**
  - Best case is 1 result per 2 cycles.
  - First res_valid appears 1 + N_OPERANDS + COMPUTE_CYCLES + 2 cycles after the IDLE->CLEAR transition, assuming back-to-back operands.
- **Boundary conditions:**
  - op_valid asserted during COMPUTE or READ is ignored (op_ready=0).
  - A new job starts only from IDLE; back-to-back jobs cost the 1-cycle CLEAR.
  - res_ready held low stalls indefinitely without data loss.
  - res_ready high before res_valid has no effect.
  - idx wraps only via return to IDLE; values >= N_RESULTS are never driven.

Optional Feature:
- Macro: MM_JOB_SEQ_TIMEOUT_EN.
- **Defined:** a counter runs while in READ_SEL with mm_done=0.
  - Reaching TIMEOUT_CYCLES: err<=1 (sticky until reset), mm_reset pulses for 1 cycle, state -> IDLE, no further results are emitted.
  - A pending res_valid is not issued.
- **Undefined:** no watchdog; READ_SEL waits forever; err is tied to 0.

Test Plan:
- Nominal job:
  - Stimulus: A = identity, B = 1..9 streamed back-to-back; res_ready=1.
  - Required: res_data sequence 1,2,...,9; res_last only on the 9th result; busy falls one cycle after the last handshake.
- Max values:
  - Stimulus: all operands 15.
  - Required: every result = 675 (3*15*15), 10-bit with no overflow.
- Operand gaps:
  - Stimulus: op_valid toggled 1/0 every cycle.
  - Required: results identical to the nominal job; mm_enable pulses exactly 18 times during LOAD.
- Output backpressure:
  - Stimulus: res_ready low for 5 cycles on results 0 and 4.
  - Required: res_data held stable, no result dropped or duplicated, order preserved.
- Reset mid-job:
  - Stimulus: reset asserted at operand 10, then a fresh nominal job.
  - Required: all outputs at their reset values the cycle after reset; the new job produces the correct 9 results.
- Timeout (MM_JOB_SEQ_TIMEOUT_EN defined):
  - Stimulus: core model holds mm_done=0.
  - Required: err=1 after 16 cycles in READ_SEL, one mm_reset pulse, return to IDLE, res_valid never asserted.
